// File: rtl/req_rsp_fifo.sv
// Request-path FIFO ahead of the loopback: DEPTH-entry valid/ready buffer with an output transfer counter.
// Latency: a word pushed at edge k is visible on out_data just after edge k (1 cycle).
// Backpressure: in_ready drops when full and depends only on registered state; there is no pass-through when full.
module req_rsp_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [$clog2(DEPTH):0]  level,
    output logic [CNT_WIDTH-1:0]    xfer_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  xfer_count_q, xfer_count_d;
    logic                  live_q, live_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  push;
    logic                  pop;

    // Pointer difference wraps naturally; the extra MSB separates full from empty.
    assign level      = wr_ptr_q - rd_ptr_q;
    // live_q keeps in_ready low while reset is held and for no longer than the first edge after release.
    assign in_ready   = live_q && (level != FULL_LVL);
    assign out_valid  = (level != '0);
    assign out_data   = mem_q[rd_ptr_q[AW-1:0]];
    assign xfer_count = xfer_count_q;
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        xfer_count_d = xfer_count_q;
        live_d       = 1'b1;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d     = rd_ptr_q + PW'(1);
            xfer_count_d = xfer_count_q + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = in_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            xfer_count_q <= '0;
            live_q       <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            xfer_count_q <= xfer_count_d;
            live_q       <= live_d;
        end
    end

    // Storage is deliberately left out of reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_req_rsp_fifo.sv
// Self-checking bench for req_rsp_fifo: directed scenarios plus randomized traffic against a queue model.
module tb_req_rsp_fifo;
    localparam int DEPTH = 4;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  level;
    logic [15:0] xfer_count;

    logic        c_in_valid;
    logic        c_in_ready;
    logic [31:0] c_in_data;
    logic        c_out_valid;
    logic        c_out_ready;
    logic [31:0] c_out_data;
    logic [2:0]  c_level;
    logic [3:0]  c_xfer;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] mq[$];
    int          exp_xfer = 0;
    int          n_push   = 0;

    req_rsp_fifo #(.DATA_WIDTH(32), .DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level), .xfer_count(xfer_count)
    );

    req_rsp_fifo #(.DATA_WIDTH(32), .DEPTH(DEPTH), .CNT_WIDTH(4)) dut_c (
        .clock(clock), .reset(reset),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .level(c_level), .xfer_count(c_xfer)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock, applying the currently driven handshakes to the reference queue.
    task automatic step();
        bit can_push;
        bit can_pop;
        can_push = (mq.size() != DEPTH);
        can_pop  = (mq.size() != 0);
        if (can_pop && out_ready) begin
            void'(mq.pop_front());
            exp_xfer++;
        end
        if (can_push && in_valid) begin
            mq.push_back(in_data);
            n_push++;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        c_in_valid = 1'b0; c_out_ready = 1'b0; c_in_data = '0;
        #2;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b exp 0", in_ready); else n_pass++;
        n_checks++; if (level !== 3'd0) $display("FAIL rst_level got %0d exp 0", level); else n_pass++;
        n_checks++; if (xfer_count !== 16'd0) $display("FAIL rst_xfer got %0d exp 0", xfer_count); else n_pass++;
        repeat (5) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL rel_in_ready_pre_edge got %b exp 0", in_ready); else n_pass++;
        @(posedge clock);
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rel_in_ready_post_edge got %b exp 1", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rel_out_valid got %b exp 0", out_valid); else n_pass++;
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 32'h0000_00A5; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL single_valid got %b exp 1", out_valid); else n_pass++;
        n_checks++; if (out_data !== 32'h0000_00A5) $display("FAIL single_data got %h exp 000000a5", out_data); else n_pass++;
        n_checks++; if (level !== 3'd1) $display("FAIL single_level1 got %0d exp 1", level); else n_pass++;
        step();
        out_ready = 1'b0;
        n_checks++; if (xfer_count !== 16'd1) $display("FAIL single_xfer got %0d exp 1", xfer_count); else n_pass++;
        n_checks++; if (level !== 3'd0) $display("FAIL single_level0 got %0d exp 0", level); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL single_empty got %b exp 0", out_valid); else n_pass++;
    endtask

    task automatic test_fill();
        int          idx;
        bit          exp_rdy;
        logic [31:0] got[$];
        idx = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = (idx < 5);
            in_data  = 32'h10 + idx;
            exp_rdy  = (mq.size() != DEPTH);
            n_checks++; if (in_ready !== exp_rdy) $display("FAIL fill_in_ready c=%0d got %b exp %b", c, in_ready, exp_rdy); else n_pass++;
            if (exp_rdy && in_valid) idx++;
            step();
        end
        n_checks++; if (level !== 3'd4) $display("FAIL fill_level got %0d exp 4", level); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL fill_full_rdy got %b exp 0", in_ready); else n_pass++;
        n_checks++; if (out_data !== 32'h10) $display("FAIL fill_head got %h exp 00000010", out_data); else n_pass++;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid = (idx < 5);
            in_data  = 32'h10 + idx;
            exp_rdy  = (mq.size() != DEPTH);
            n_checks++; if (in_ready !== exp_rdy) $display("FAIL drain_in_ready c=%0d got %b exp %b", c, in_ready, exp_rdy); else n_pass++;
            if (out_valid === 1'b1) got.push_back(out_data);
            if (exp_rdy && in_valid) idx++;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_checks++; if (got.size() != 5) $display("FAIL fill_order_count got %0d exp 5", got.size()); else n_pass++;
        for (int i = 0; i < got.size() && i < 5; i++) begin
            n_checks++; if (got[i] !== 32'h10 + i) $display("FAIL fill_order[%0d] got %h exp %h", i, got[i], 32'h10 + i); else n_pass++;
        end
    endtask

    task automatic test_streaming();
        int start;
        start = exp_xfer;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_data = 32'h1000 + i;
            if (i > 0) begin
                n_checks++; if (out_valid !== 1'b1 || out_data !== 32'h1000 + i - 1)
                    $display("FAIL stream_out i=%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, 32'h1000 + i - 1); else n_pass++;
                n_checks++; if (level > 3'd1) $display("FAIL stream_level i=%0d got %0d exp <=1", i, level); else n_pass++;
            end
            step();
        end
        in_valid = 1'b0;
        n_checks++; if (out_data !== 32'h1000 + 99) $display("FAIL stream_last got %h exp %h", out_data, 32'h1000 + 99); else n_pass++;
        step();
        out_ready = 1'b0;
        n_checks++; if (level !== 3'd0) $display("FAIL stream_drain got %0d exp 0", level); else n_pass++;
        n_checks++; if (xfer_count - 16'(start) !== 16'd100)
            $display("FAIL stream_xfer got %0d exp 100", xfer_count - 16'(start)); else n_pass++;
    endtask

    task automatic test_random();
        int  start_push;
        bit  done;
        start_push = n_push;
        done = 1'b0;
        for (int c = 0; c < 20000 && !done; c++) begin
            n_checks++; if (level !== 3'(mq.size()) || level > 3'd4)
                $display("FAIL rand_level c=%0d got %0d exp %0d", c, level, mq.size()); else n_pass++;
            n_checks++; if (in_ready !== (mq.size() != DEPTH) || out_valid !== (mq.size() != 0))
                $display("FAIL rand_flags c=%0d got rdy=%b vld=%b exp size %0d", c, in_ready, out_valid, mq.size()); else n_pass++;
            if (mq.size() != 0) begin
                n_checks++; if (out_data !== mq[0]) $display("FAIL rand_data c=%0d got %h exp %h", c, out_data, mq[0]); else n_pass++;
            end
            if (n_push - start_push >= 1000 && mq.size() == 0) begin
                done = 1'b1;
            end else begin
                in_valid  = (n_push - start_push < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
                in_data   = $urandom;
                out_ready = 1'($urandom_range(0, 1));
                step();
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_checks++; if (!done) $display("FAIL rand_timeout got %0d pushes exp 1000 drained", n_push - start_push); else n_pass++;
        n_checks++; if (xfer_count !== 16'(exp_xfer)) $display("FAIL rand_xfer got %0d exp %0d", xfer_count, 16'(exp_xfer)); else n_pass++;
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'h5500 + i;
            step();
        end
        in_valid = 1'b0;
        n_checks++; if (level !== 3'd3) $display("FAIL mid_pre_level got %0d exp 3", level); else n_pass++;
        #1 reset = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL mid_flags got vld=%b rdy=%b exp 0 0", out_valid, in_ready); else n_pass++;
        n_checks++; if (level !== 3'd0 || xfer_count !== 16'd0)
            $display("FAIL mid_state got level=%0d xfer=%0d exp 0 0", level, xfer_count); else n_pass++;
        #1 reset = 1'b1;
        mq.delete();
        exp_xfer = 0;
        @(posedge clock);
        #1;
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL mid_release got rdy=%b vld=%b exp 1 0", in_ready, out_valid); else n_pass++;
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF)
            $display("FAIL mid_first_word got vld=%b d=%h exp 1 deadbeef", out_valid, out_data); else n_pass++;
        step();
        out_ready = 1'b0;
        n_checks++; if (xfer_count !== 16'd1 || level !== 3'd0)
            $display("FAIL mid_after got xfer=%0d level=%0d exp 1 0", xfer_count, level); else n_pass++;
    endtask

    task automatic test_cnt_wrap();
        c_out_ready = 1'b1;
        for (int n = 1; n <= 17; n++) begin
            c_in_valid = 1'b1; c_in_data = 32'(n);
            @(posedge clock); #1;
            c_in_valid = 1'b0;
            @(posedge clock); #1;
            n_checks++; if (c_xfer !== 4'(n % 16)) $display("FAIL cnt_wrap n=%0d got %0d exp %0d", n, c_xfer, n % 16); else n_pass++;
        end
        c_out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_streaming();
        test_random();
        test_mid_reset();
        test_cnt_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/req_rsp_fifo.md
# req_rsp_fifo

Parameterised valid/ready buffer placed on the request path ahead of `ReqRspLoopback`. It accepts 32-bit request words from a Python-driven producer and presents them in order to the loopback's request input. This decouples producer stalls from loopback back-pressure and absorbs bursts. It also counts completed output transfers so the Python side can check progress without sampling the bus.

## Interface
- `DATA_WIDTH`, 32, width of each request word.
- `DEPTH`, 4, number of entries; power of two, ≥ 2.
- `CNT_WIDTH`, 16, width of the transfer counter.

- `clock` input 1 single clock; all state updates on the rising edge.
- `reset` input 1 asynchronous, active-low reset.
- `in_valid` input 1 producer has a word on `in_data`.
- `in_ready` output 1 buffer can accept a word this cycle.
- `in_data` input DATA_WIDTH incoming request word.
- `out_valid` output 1 head entry is valid on `out_data`.
- `out_ready` input 1 downstream (loopback `req_ready`) accepts the head word.
- `out_data` output DATA_WIDTH head-of-queue word.
- `level` output $clog2(DEPTH)+1 current occupancy, 0..DEPTH.
- `xfer_count` output CNT_WIDTH number of completed output handshakes, modulo 2^CNT_WIDTH.

## Operation
- Storage: DEPTH-entry register array; write pointer and read pointer are $clog2(DEPTH)+1 bits wide.
- The low bits of each pointer index the array. The MSB disambiguates full from empty.
- Push occurs when `in_valid && in_ready`: write `in_data` at `wr_ptr`, then `wr_ptr` += 1.
- Pop occurs when `out_valid && out_ready`: `rd_ptr` += 1 and `xfer_count` += 1.
- Push and pop in the same cycle are both performed; `level` is unchanged.
- `level` = `wr_ptr - rd_ptr`, computed modulo 2^($clog2(DEPTH)+1).
- `in_ready` = (`level` != DEPTH).
  - Depends only on registered state, never on `out_ready`.
  - There is no same-cycle pass-through when full.
- `out_valid` = (`level` != 0). `out_data` = `array[rd_ptr low bits]`, read combinationally from registered state.
- Ordering is strict FIFO; no word is dropped or duplicated.
- `xfer_count` wraps from 2^CNT_WIDTH−1 to 0 without any flag.
- Array contents are not reset. `out_data` is undefined while `out_valid` = 0.

## Timing
- Reset asserted (`reset` = 0) takes effect immediately, with no clock required:
  - pointers = 0, `level` = 0, `xfer_count` = 0;
  - `out_valid` = 0, `in_ready` = 0.
- First rising edge after `reset` goes high: `in_ready` = 1.
- Write-to-read latency is 1 cycle. A word pushed at edge k gives `out_valid` = 1 with that word from just after edge k.
- Full boundary: once `level` = DEPTH, `in_ready` = 0.
  - A pop at edge k raises `in_ready` after edge k.
  - A push in the same cycle as the pop is not accepted.
- Empty boundary: when `level` = 0, `out_valid` = 0 and `out_ready` is ignored.
- Pointer wrap: after DEPTH pushes, `wr_ptr` low bits return to 0. Full and empty detection stays correct across any number of wraps.
- Reset mid-operation: all stored words are discarded. After release, the buffer is empty and `xfer_count` = 0.
- `out_valid` and `out_data` stay stable while `out_valid && !out_ready`.

## Test plan
- Single word: reset 5 cycles, push 0x0000_00A5 with `out_ready` = 1.
  - Required: `out_valid` high 1 cycle after accept with 0x0000_00A5.
  - Required: `xfer_count` = 1, `level` returns to 0.
- Fill to full: `out_ready` = 0, offer 0x10..0x14 (DEPTH = 4).
  - Required: 0x10–0x13 accepted, `level` = 4, `in_ready` = 0, 0x14 held by producer.
  - Release `out_ready`. Required: output order 0x10, 0x11, 0x12, 0x13, 0x14.
- Streaming: `in_valid` and `out_ready` both held high for 100 cycles with an incrementing pattern.
  - Required: one transfer per cycle after the first, `level` ≤ 1, `xfer_count` = 100 at the end, no gaps or duplicates.
- Random back-pressure: 1000 words with random `in_valid`/`out_ready` (50 %).
  - Required: scoreboard exact match, `level` always 0..4, 4-entry pointer wrap exercised ≥ 250 times.
- Reset mid-stream: with `level` = 3, pulse `reset` low for 2 ns off-edge.
  - Required: `out_valid`, `in_ready`, `level`, `xfer_count` go to 0 immediately.
  - Required: the next pushed word 0xDEAD_BEEF is the first word output.
- Counter wrap (`CNT_WIDTH` = 4): 17 transfers. Required: `xfer_count` reads 15 after 15 transfers, 0 after 16, 1 after 17.
